// File: rtl/sram_arbiter_512x32_pkg.sv
// Shared constants and types for the 512x32 SRAM arbiter.
// Geometry of the wrapped macro and the arbiter state encoding.
package sram_arbiter_512x32_pkg;

  localparam int SRAM_AW = 9;
  localparam int SRAM_DW = 32;
  localparam int SRAM_NB = SRAM_DW / 8;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/sram_arbiter_512x32_rr_arbiter2.sv
// Two-request round-robin picker; req[0]/gnt[0] is port A, req[1]/gnt[1] is port B.
// The one-hot grant is combinational; `last` remembers the most recent winner.
module rr_arbiter2
  import sram_arbiter_512x32_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || last == PORT_B)) gnt = 2'b01;
      else if (req[1])                           gnt = 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)       last <= PORT_A;
    else if (gnt[0]) last <= PORT_A;
    else if (gnt[1]) last <= PORT_B;
  end

endmodule

// File: rtl/sram_arbiter_512x32.sv
// Shares one 512x32 single-port SRAM between a fetch port (A) and a data port (B),
// turning byte-masked writes into a two-cycle read-modify-write.
module sram_arbiter_512x32
  import sram_arbiter_512x32_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int DW = SRAM_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic            b_we,
  input  logic [DW/8-1:0] b_wstrb,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,
  output logic            sram_en,
  output logic            sram_wen,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  localparam int NB = DW / 8;

  state_e          state;
  logic [1:0]      gnt;
  logic            b_partial;
  logic [AW-1:0]   rmw_addr;
  logic [DW-1:0]   rmw_wdata;
  logic [NB-1:0]   rmw_wstrb;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_RUN && !reset),
    .req    ({b_valid, a_valid}),
    .gnt    (gnt)
  );

  assign a_ready   = gnt[0];
  assign b_ready   = gnt[1];
  assign b_partial = b_we && (b_wstrb != '0) && (b_wstrb != '1);

  assign a_rdata = a_rvalid ? sram_rdata : '0;
  assign b_rdata = b_rvalid ? sram_rdata : '0;

  // SRAM side is purely combinational; reset masks the RMW write so a pending merge is dropped.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state == ST_RMW_WR && !reset) begin
      sram_en   = 1'b1;
      sram_wen  = 1'b1;
      sram_addr = rmw_addr;
      for (int i = 0; i < NB; i++)
        sram_wdata[8*i +: 8] = rmw_wstrb[i] ? rmw_wdata[8*i +: 8] : sram_rdata[8*i +: 8];
    end else if (gnt[0]) begin
      sram_en   = 1'b1;
      sram_addr = a_addr;
    end else if (gnt[1]) begin
      sram_addr = b_addr;
      if (!b_we || b_partial) begin
        sram_en = 1'b1;
      end else if (b_wstrb == '1) begin
        sram_en    = 1'b1;
        sram_wen   = 1'b1;
        sram_wdata = b_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= gnt[0];
      b_rvalid <= gnt[1] && !b_we;
      case (state)
        ST_RUN:    if (gnt[1] && b_partial) state <= ST_RMW_WR;
        ST_RMW_WR: state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // NOTE: pure datapath capture registers carry no reset; they are only consumed in ST_RMW_WR.
  always_ff @(posedge clk) begin
    if (gnt[1] && b_partial) begin
      rmw_addr  <= b_addr;
      rmw_wdata <= b_wdata;
      rmw_wstrb <= b_wstrb;
    end
  end

endmodule

// File: tb/tb_sram_arbiter_512x32.sv
// Scoreboard bench for sram_arbiter_512x32 with a behavioural SRAM and reference memory.
module tb_sram_arbiter_512x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_rvalid;
  logic [8:0]  a_addr;
  logic [31:0] a_rdata;
  logic        b_valid, b_ready, b_we, b_rvalid;
  logic [8:0]  b_addr;
  logic [3:0]  b_wstrb;
  logic [31:0] b_wdata, b_rdata;
  logic        sram_en, sram_wen;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  sram_arbiter_512x32 dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_we(b_we),
    .b_wstrb(b_wstrb), .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: read data appears the cycle after the read.
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen) mem[sram_addr] = sram_wdata;
      else          sram_rdata <= mem[sram_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  // Reference model: expected memory contents, fairness owner and pending merged write.
  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t        qa[$], qb[$];
  logic [31:0] ref_mem [0:511];
  logic        m_last_b, m_busy;
  logic [8:0]  p_addr;
  logic [31:0] p_data;
  logic        e_a, e_b, e_en, e_wen, e_chk_wd;
  logic [8:0]  e_addr;
  logic [31:0] e_wd;

  always @(negedge clk) begin
    e_a = 0; e_b = 0; e_en = 0; e_wen = 0; e_addr = 0; e_wd = 0; e_chk_wd = 0;
    if (reset) begin
      m_last_b = 0;
      m_busy   = 0;
    end else if (m_busy) begin
      e_en = 1; e_wen = 1; e_addr = p_addr; e_wd = p_data; e_chk_wd = 1;
      ref_mem[p_addr] = p_data;
      m_busy = 0;
    end else begin
      if (a_valid && (!b_valid || m_last_b)) e_a = 1;
      else if (b_valid)                      e_b = 1;
      if (e_a) begin
        e_en = 1; e_addr = a_addr; m_last_b = 0;
        qa.push_back('{ref_mem[a_addr], cyc + 1});
      end
      if (e_b) begin
        m_last_b = 1; e_addr = b_addr;
        if (!b_we) begin
          e_en = 1;
          qb.push_back('{ref_mem[b_addr], cyc + 1});
        end else if (b_wstrb == 4'hF) begin
          e_en = 1; e_wen = 1; e_wd = b_wdata; e_chk_wd = 1;
          ref_mem[b_addr] = b_wdata;
        end else if (b_wstrb != 4'h0) begin
          e_en = 1; m_busy = 1; p_addr = b_addr;
          p_data = merge(ref_mem[b_addr], b_wdata, b_wstrb);
        end
      end
    end
    check("a_ready", a_ready, e_a);
    check("b_ready", b_ready, e_b);
    check("sram_en", sram_en, e_en);
    check("sram_wen", sram_wen, e_wen);
    if (e_en) check("sram_addr", sram_addr, e_addr);
    if (e_chk_wd) check("sram_wdata", sram_wdata, e_wd);
  end

  // Monitor: pops the scoreboard whenever a read response is presented.
  exp_t got_a, got_b;
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        got_a = qa.pop_front();
        check("a_rvalid_cycle", cyc, got_a.due);
        check("a_rdata", a_rdata, got_a.data);
      end
    end else begin
      check("a_rdata_idle", a_rdata, 32'h0);
      if (qa.size() != 0 && qa[0].due <= cyc) check("a_rvalid_missing", 0, 1);
    end
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        got_b = qb.pop_front();
        check("b_rvalid_cycle", cyc, got_b.due);
        check("b_rdata", b_rdata, got_b.data);
      end
    end else begin
      check("b_rdata_idle", b_rdata, 32'h0);
      if (qb.size() != 0 && qb[0].due <= cyc) check("b_rvalid_missing", 0, 1);
    end
  end

  task automatic a_req(input logic [8:0] addr);
    int n = 0;
    a_valid = 1; a_addr = addr;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_ready) check("a_req_timeout", 0, 1);
    @(posedge clk); #1;
    a_valid = 0;
  endtask

  task automatic b_req(input logic [8:0] addr, input logic we, input logic [3:0] strb,
                       input logic [31:0] data);
    int n = 0;
    b_valid = 1; b_addr = addr; b_we = we; b_wstrb = strb; b_wdata = data;
    @(negedge clk);
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_ready) check("b_req_timeout", 0, 1);
    @(posedge clk); #1;
    b_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] saved;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[9'h005] = 32'hDEADBEEF; ref_mem[9'h005] = 32'hDEADBEEF;
    mem[9'h010] = 32'h11223344; ref_mem[9'h010] = 32'h11223344;
    sram_rdata = 0;
    a_valid = 0; a_addr = 0;
    b_valid = 0; b_addr = 0; b_we = 0; b_wstrb = 0; b_wdata = 0;
    reset = 1;
    @(negedge clk);
    check("reset_a_rvalid", a_rvalid, 0);
    check("reset_b_rvalid", b_rvalid, 0);
    @(posedge clk); #1 reset = 0;

    a_req(9'h005);
    idle(2);

    // Contention from reset: B wins first, then strict alternation.
    do_reset();
    fork
      for (int i = 0; i < 6; i++) a_req(9'(i));
      for (int j = 0; j < 6; j++) b_req(9'(j + 8), 1'b0, 4'h0, 32'h0);
    join
    idle(2);

    b_req(9'h1FF, 1'b1, 4'hF, 32'h12345678);
    a_req(9'h1FF);
    idle(2);
    check("full_write_mem", mem[9'h1FF], 32'h12345678);

    b_req(9'h010, 1'b1, 4'b0101, 32'hAABBCCDD);
    a_req(9'h010);
    idle(2);
    check("rmw_merge_mem", mem[9'h010], 32'h11BB33DD);

    saved = mem[9'h020];
    b_req(9'h020, 1'b1, 4'h0, 32'hFFFFFFFF);
    idle(2);
    check("null_write_mem", mem[9'h020], saved);

    // Reset lands on the RMW write cycle: the merge must be dropped.
    saved = mem[9'h030];
    b_req(9'h030, 1'b1, 4'b0011, 32'hCAFEF00D);
    reset = 1;
    @(negedge clk);
    check("rst_rmw_a_rvalid", a_rvalid, 0);
    check("rst_rmw_b_rvalid", b_rvalid, 0);
    @(posedge clk); #1 reset = 0;
    check("rst_rmw_mem", mem[9'h030], saved);
    fork
      a_req(9'h031);
      b_req(9'h032, 1'b0, 4'h0, 32'h0);
    join
    idle(2);

    fork
      repeat (150) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        else a_req(9'($urandom_range(64, 79)));
      end
      repeat (150) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        else case ($urandom_range(0, 3))
          0:       b_req(9'($urandom_range(64, 79)), 1'b0, 4'h0, 32'h0);
          1:       b_req(9'($urandom_range(64, 79)), 1'b1, 4'hF, $urandom);
          default: b_req(9'($urandom_range(64, 79)), 1'b1, 4'($urandom_range(0, 15)), $urandom);
        endcase
      end
    join
    idle(4);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    for (int k = 64; k < 80; k++) check("final_mem", mem[k], ref_mem[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_512x32.md
# sram_arbiter_512x32

Two-port arbiter and sequencer for the 512x32 single-port SRAM wrapper. Shares one SRAM macro between an instruction-fetch port (port A, read-only) and a data port (port B, read/write with byte strobes). Byte-masked writes are converted into read-modify-write sequences because the SRAM wrapper only supports whole-word writes. Sits between the minimax core's fetch/LSU interfaces and `gf180mcu_sram_512x32`.

## Interface
- `AW`, 9: word address width.
- `DW`, 32: data width; must be 32, with 4 strobes.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `a_valid` in 1: fetch request.
- `a_ready` out 1: fetch request accepted this cycle.
- `a_addr` in AW: fetch word address.
- `a_rvalid` out 1: fetch read data valid.
- `a_rdata` out DW: fetch read data.
- `b_valid` in 1: data request.
- `b_ready` out 1: data request accepted this cycle.
- `b_addr` in AW: data word address.
- `b_we` in 1: 1 = write, 0 = read.
- `b_wstrb` in 4: byte write strobes; ignored when `b_we` = 0.
- `b_wdata` in DW: write data.
- `b_rvalid` out 1: data read data valid.
- `b_rdata` out DW: data read data.
- `sram_en` out 1: SRAM access enable, one cycle per access.
- `sram_wen` out 1: SRAM word write.
- `sram_addr` out AW: SRAM address.
- `sram_wdata` out DW: SRAM write data.
- `sram_rdata` in DW: SRAM read data; valid in the cycle after the read.

## Operation
- FSM states:
  - RUN: issue at most one access per cycle.
  - RMW_WR: second cycle of a partial write.
- RUN arbitration:
  - Round-robin between A and B, using a 1-bit `last` register.
  - When both valids are high, the port not equal to `last` wins. `last` updates on every grant.
  - A lone valid always wins.
  - `a_ready`/`b_ready` are combinational: asserted for the granted port in RUN; both are 0 in RMW_WR and during reset.
- Grant types:
  - Read grant (A, or B with `b_we` = 0): `sram_en` = 1, `sram_wen` = 0, `sram_addr` = requester address.
  - Full write (`b_wstrb` = 1111): `sram_en` = 1, `sram_wen` = 1, `sram_wdata` = `b_wdata`. Single cycle. No response.
  - Partial write (strobe not 0000 and not 1111), first cycle: issue a read of `b_addr`; latch address, wdata and strobes; go to RMW_WR.
  - Null write (strobe 0000): accepted, no SRAM access, no response.
- RMW_WR:
  - Write `sram_wdata` = per-byte mux, taking `b_wdata` byte where strobe = 1 and `sram_rdata` byte otherwise.
  - `sram_en` = 1, `sram_wen` = 1, address = latched address.
  - Return to RUN. No rvalid is generated for either cycle.
- Read response: `x_rvalid` is registered and asserted for exactly one cycle after that port's read grant. `x_rdata` = `sram_rdata` while `x_rvalid` = 1, else 0.
- Reset values:
  - `last` = A, so B wins the first contention.
  - State = RUN.
  - `a_rvalid` = `b_rvalid` = 0, `sram_en` = `sram_wen` = 0.
- Reset during RMW_WR: the pending write is dropped and no SRAM write occurs.
- Requesters must hold address and data stable while valid and not ready.

## Timing
- Read latency: grant at cycle N, rvalid and data at cycle N+1.
- Back-to-back reads sustain 1 access per cycle. Alternating A/B under contention gives each port 1 access per 2 cycles.
- Partial write occupies 2 SRAM cycles: the port that would win next is stalled 1 cycle.
- Read-after-RMW to the same address issued in the following RUN cycle returns the merged word, since the write completes first.
- Outputs toward the SRAM are combinational from state and grant. No registered SRAM-side delay is added.

## Structure
- Shared header `minimax_sram_defs.vh`: `SRAM_AW`=9, `SRAM_DW`=32, state encodings `ST_RUN`/`ST_RMW_WR`.
- Sub-module `rr_arbiter2`: 2-request round-robin picker with `last` register, producing a one-hot grant.
- The byte merge is inline logic.

## Test plan
- Single A read at addr 0x005, pre-loaded with 0xDEADBEEF: `a_ready` in the same cycle, `a_rvalid` = 1 with 0xDEADBEEF the next cycle, `b_rvalid` = 0.
- A and B reading continuously from reset: grants go B, A, B, A…; each port's rvalid pattern is 0101… with correct data.
- B full write of 0x12345678 to 0x1FF, then A reads 0x1FF: read returns 0x12345678; the write produces `sram_en`+`sram_wen` for exactly 1 cycle.
- B partial write, strobe 0101 and data 0xAABBCCDD, over 0x11223344 at 0x010: 2-cycle sequence with `b_ready` low in cycle 2. Subsequent read returns 0x11BB33DD.
- Null write (strobe 0000): accepted in 1 cycle, no `sram_en`, memory unchanged.
- Reset asserted in RMW_WR: no write occurs, memory keeps its old value, all rvalids are 0, and the next contention is granted to B.
